// File: rtl/mem_dump.sv
// mem_dump: serial-commanded memory dump engine.
// Streams each 16-bit word as high/low bytes, followed by an ACK byte.
module mem_dump #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter logic [7:0] OPCODE = 8'h52,
  parameter logic [7:0] ACK_BYTE = 8'h06
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic [7:0] serial_data_in,
  input  logic serial_in_cplt,
  input  logic serial_in_error,
  input  logic serial_out_rdy,
  output logic [7:0] serial_data_out,
  output logic serial_out_en,
  input  logic mem_rdy,
  input  logic mem_cplt,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic mem_r_en,
  output logic mem_w_en,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, CMD_ADDR, CMD_LEN, MEM_REQ, MEM_WAIT, TX_HI, TX_LO, TX_ACK} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0] idx_q, idx_d;
  logic r_en_q, r_en_d;
  logic tx_en_q, tx_en_d;
  logic [7:0] tx_q, tx_d;
  logic tx_go;
  logic [15:0] len_nxt;
  // ready seen during a strobe cycle is stale; wait one clk before trusting it again
  assign tx_go = serial_out_rdy && !tx_en_q;
  assign len_nxt = {cnt_q[7:0], serial_data_in};
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    data_d = data_q;
    idx_d = idx_q;
    r_en_d = 1'b0;
    tx_en_d = 1'b0;
    tx_d = tx_q;
    if (state_q != IDLE && !enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          idx_d = 2'd0;
          if (enable && serial_in_cplt && serial_data_in == OPCODE) state_d = CMD_ADDR;
        end
        CMD_ADDR: begin
          if (serial_in_error) begin
            state_d = IDLE;
          end else if (serial_in_cplt) begin
            addr_d = {addr_q[ADDR_WIDTH-9:0], serial_data_in};
            idx_d = idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1;
            state_d = idx_q == 2'd2 ? CMD_LEN : CMD_ADDR;
          end
        end
        CMD_LEN: begin
          if (serial_in_error) begin
            state_d = IDLE;
          end else if (serial_in_cplt) begin
            cnt_d = len_nxt;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd1) state_d = len_nxt == 16'd0 ? TX_ACK : MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_rdy) begin
            r_en_d = 1'b1;
            state_d = MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_cplt) begin
            data_d = mem_data_out;
            state_d = TX_HI;
          end
        end
        TX_HI: begin
          if (tx_go) begin
            tx_en_d = 1'b1;
            tx_d = data_q[DATA_WIDTH-1 -: 8];
            state_d = TX_LO;
          end
        end
        TX_LO: begin
          if (tx_go) begin
            tx_en_d = 1'b1;
            tx_d = data_q[7:0];
            addr_d = addr_q + 1'b1;
            cnt_d = cnt_q - 1'b1;
            state_d = cnt_q == 16'd1 ? TX_ACK : MEM_REQ;
          end
        end
        TX_ACK: begin
          if (tx_go) begin
            tx_en_d = 1'b1;
            tx_d = ACK_BYTE;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      idx_q <= '0;
      r_en_q <= 1'b0;
      tx_en_q <= 1'b0;
      tx_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      idx_q <= idx_d;
      r_en_q <= r_en_d;
      tx_en_q <= tx_en_d;
      tx_q <= tx_d;
    end
  end
  assign serial_data_out = tx_q;
  assign serial_out_en = tx_en_q;
  assign mem_addr = addr_q;
  assign mem_r_en = r_en_q;
  assign mem_w_en = 1'b0;
  assign mem_data_in = '0;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_mem_dump.sv
// tb_mem_dump: table-driven and randomized checks of mem_dump against a queue-based dump model.
module tb_mem_dump;
  localparam logic [7:0] OP = 8'h52;
  localparam logic [7:0] ACK = 8'h06;
  logic clk = 0, rst = 1, enable = 0;
  logic [7:0] serial_data_in = 0;
  logic serial_in_cplt = 0, serial_in_error = 0, serial_out_rdy = 0;
  logic [7:0] serial_data_out;
  logic serial_out_en;
  logic mem_rdy = 0, mem_cplt = 0;
  logic [15:0] mem_data_out = 0;
  logic [23:0] mem_addr;
  logic mem_r_en, mem_w_en;
  logic [15:0] mem_data_in;
  logic busy;
  always #5 clk = ~clk;
  mem_dump dut (
    .clk(clk), .rst(rst), .enable(enable),
    .serial_data_in(serial_data_in), .serial_in_cplt(serial_in_cplt), .serial_in_error(serial_in_error),
    .serial_out_rdy(serial_out_rdy), .serial_data_out(serial_data_out), .serial_out_en(serial_out_en),
    .mem_rdy(mem_rdy), .mem_cplt(mem_cplt), .mem_data_out(mem_data_out),
    .mem_addr(mem_addr), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_data_in(mem_data_in),
    .busy(busy)
  );
  typedef struct { logic [23:0] addr; logic [15:0] len; int exp_n; } vec_t;
  int nvec = 0, nerr = 0;
  logic [7:0] got[$];
  logic [23:0] rd[$];
  int tx_mode = 0, mem_hold = 0, mem_rand = 0;
  logic pend = 0;
  logic [23:0] pend_addr = 0;
  int pend_dly = 0;
  logic tx_rdy_s = 0, mem_rdy_s = 0, prev_strobe = 0;
  function automatic logic [15:0] memval(input logic [23:0] a);
    if (a == 24'h000100) return 16'hA1B2;
    if (a == 24'h000101) return 16'hC3D4;
    return {a[7:0] ^ 8'hA5, a[15:8] + a[23:16] + 8'h3C};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    tx_rdy_s <= serial_out_rdy;
    mem_rdy_s <= mem_rdy;
  end
  // monitor plus memory and TX-ready models, all on the inactive edge
  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
      prev_strobe = 0;
    end else begin
      if (serial_out_en) begin
        got.push_back(serial_data_out);
        chk("strobe_rdy", {31'b0, tx_rdy_s & ~prev_strobe}, 32'd1);
        if (tx_mode == 3) tx_mode = 2;
      end
      if (mem_r_en) begin
        rd.push_back(mem_addr);
        chk("rd_rdy_single", {30'b0, mem_rdy_s, pend}, 32'd2);
        pend = 1;
        pend_addr = mem_addr;
        pend_dly = $urandom_range(1, 4);
      end else if (pend && busy) begin
        chk("addr_hold", {8'b0, mem_addr}, {8'b0, pend_addr});
      end
      prev_strobe = serial_out_en;
    end
    mem_cplt = 0;
    mem_data_out = 16'($urandom);
    if (pend && !rst) begin
      if (pend_dly == 0) begin
        mem_cplt = 1;
        mem_data_out = memval(pend_addr);
        pend = 0;
      end else pend_dly--;
    end
    serial_out_rdy = (tx_mode == 0 || tx_mode == 3) ? 1'b1 : tx_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    if (mem_hold > 0) begin
      mem_rdy = 0;
      mem_hold--;
    end else mem_rdy = mem_rand != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic send(input logic [7:0] b, input logic err);
    @(negedge clk);
    serial_data_in = b;
    serial_in_cplt = !err;
    serial_in_error = err;
    @(negedge clk);
    serial_in_cplt = 0;
    serial_in_error = 0;
    serial_data_in = 8'($urandom);
  endtask
  task automatic send_cmd(input logic [23:0] a, input logic [15:0] len);
    send(OP, 0);
    send(a[23:16], 0);
    send(a[15:8], 0);
    send(a[7:0], 0);
    send(len[15:8], 0);
    send(len[7:0], 0);
  endtask
  task automatic run_vec(input logic [23:0] a, input logic [15:0] len, input int exp_n, input logic stray);
    logic [7:0] exp[$];
    logic [15:0] w;
    int n;
    got.delete();
    rd.delete();
    send_cmd(a, len);
    if (stray) send(OP, 0);
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle", {31'b0, busy}, 32'd0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < int'(len); i++) begin
      w = memval(24'(a + 24'(i)));
      exp.push_back(w[15:8]);
      exp.push_back(w[7:0]);
    end
    exp.push_back(ACK);
    chk("nbytes", got.size(), exp_n);
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk("byte", {24'b0, got[i]}, {24'b0, exp[i]});
    chk("nreads", rd.size(), {16'b0, len});
    for (int i = 0; i < int'(len) && i < rd.size(); i++) chk("rd_addr", {8'b0, rd[i]}, {8'b0, 24'(a + 24'(i))});
  endtask
  initial begin : main
    vec_t tbl[6];
    int n;
    logic [15:0] len;
    logic [23:0] a;
    tbl = '{'{24'h000100, 16'd2, 5}, '{24'hFFFFFF, 16'd2, 5}, '{24'h000010, 16'd0, 1},
            '{24'h123456, 16'd1, 3}, '{24'h00FFFE, 16'd4, 9}, '{24'hFFFFFE, 16'd3, 7}};
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_r_en", {31'b0, mem_r_en}, 0);
    chk("rst_out_en", {31'b0, serial_out_en}, 0);
    chk("rst_addr", {8'b0, mem_addr}, 0);
    chk("rst_dout", {24'b0, serial_data_out}, 0);
    chk("w_tie", {15'b0, mem_w_en, mem_data_in}, 0);
    rst = 0;
    enable = 1;
    repeat (2) @(negedge clk);
    foreach (tbl[i]) run_vec(tbl[i].addr, tbl[i].len, tbl[i].exp_n, 0);
    got.delete();
    rd.delete();
    send(8'h41, 0);
    send(OP, 0);
    send(8'h00, 0);
    send(8'h00, 1);
    repeat (3) @(negedge clk);
    chk("err_busy", {31'b0, busy}, 0);
    chk("err_quiet", got.size() + rd.size(), 0);
    run_vec(24'h000100, 16'd2, 5, 0);
    tx_mode = 1;
    mem_hold = 20;
    run_vec(24'h0ABCDE, 16'd3, 7, 1);
    mem_rand = 1;
    for (int i = 0; i < 10; i++) begin
      len = 16'($urandom_range(0, 6));
      a = (i % 3 == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 3)) : 24'($urandom);
      run_vec(a, len, 2 * int'(len) + 1, len != 0);
    end
    tx_mode = 0;
    mem_rand = 0;
    got.delete();
    rd.delete();
    send_cmd(24'h000200, 16'd3);
    n = 0;
    while (!mem_r_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_rd_seen", {31'b0, mem_r_en}, 1);
    enable = 0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_tx", got.size(), 0);
    chk("abort_no_rd", rd.size(), 1);
    enable = 1;
    got.delete();
    rd.delete();
    tx_mode = 3;
    send_cmd(24'h000300, 16'd2);
    n = 0;
    while (tx_mode != 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("txlo_reached", tx_mode, 2);
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 0);
    chk("rst_mid_en", {30'b0, serial_out_en, mem_r_en}, 0);
    @(negedge clk);
    rst = 0;
    tx_mode = 0;
    repeat (30) @(negedge clk);
    chk("rst_no_tx", got.size(), 1);
    chk("rst_no_rd", rd.size(), 1);
    chk("rst_idle", {31'b0, busy}, 0);
    run_vec(24'h000100, 16'd2, 5, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
